// File: rtl/keypad_pkg.sv
// Shared types, the phone-layout key map and the code-width helper for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_e;

    // Indexed by row*3 + col: rows read 1 2 3 / 4 5 6 / 7 8 9 / A 0 B
    localparam logic [11:0][3:0] PHONE_MAP = {
        4'hB, 4'h0, 4'hA,
        4'h9, 4'h8, 4'h7,
        4'h6, 4'h5, 4'h4,
        4'h3, 4'h2, 4'h1
    };

    function automatic int codeWidth(input int numRows, input int numCols);
        int w;
        w = $clog2(numRows * numCols);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/key_debounce_ctr.sv
// Match counter for press/release debouncing; lastO flags that the next increment hits LIMIT.
module key_debounce_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    logic [7:0] count_q;

    // Clear with increment loads 1, which starts a fresh run on the current sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= inc_i ? 8'd1 : 8'd0;
        end else if (inc_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign last_o = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/keypad_scan.sv
// Row-scanning matrix keypad controller with debounced press/release detection.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter  int NUM_ROWS     = 4,
    parameter  int NUM_COLS     = 3,
    parameter  int SCAN_DIV     = 16,
    parameter  int DEBOUNCE_CNT = 4,
    parameter  int MAP_MODE     = 1,
    localparam int CODE_W       = codeWidth(NUM_ROWS, NUM_COLS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_COLS-1:0] cols_i,
    output logic [NUM_ROWS-1:0] rows_o,
    output logic [CODE_W-1:0]   key_code_o,
    output logic                key_valid_o,
    output logic                key_held_o,
    output logic                key_release_o
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int DW = $clog2(SCAN_DIV);

    if (MAP_MODE == 1 && !(NUM_ROWS == 4 && NUM_COLS == 3)) begin : gBadMap
        $error("keypad_scan: MAP_MODE=1 needs a 4x3 keypad");
    end
    if (MAP_MODE < 0 || MAP_MODE > 1 || NUM_ROWS < 2 || NUM_ROWS > 16 || NUM_COLS < 2 ||
        NUM_COLS > 16 || SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 255) begin : gBadParam
        $error("keypad_scan: parameter out of legal range");
    end

    scan_state_e         state_q;
    logic [DW-1:0]       dwell_q;
    logic [NUM_ROWS-1:0] rows_q;
    logic [RW-1:0]       rowIdx_q;
    logic [NUM_COLS-1:0] colsLatch_q;
    logic [CW-1:0]       colIdx_q;
    logic [CODE_W-1:0]   keyCode_q;
    logic                keyValid_q;
    logic                keyHeld_q;
    logic                keyRelease_q;

    logic                sampleEdge;
    logic                colsZero;
    logic                colsOneHot;
    logic                colsMatch;
    logic [CW-1:0]       colNow;
    logic [CW-1:0]       capCol;
    logic [NUM_ROWS-1:0] rowsNext;
    logic [RW-1:0]       rowIdxNext;
    int unsigned         keyIdx;
    logic [CODE_W-1:0]   newCode;
    logic                cntClr;
    logic                cntInc;
    logic                cntLast;

    // Counter is told to restart or extend its run only on sample edges, mirroring the FSM.
    always_comb begin
        sampleEdge = (dwell_q == DW'(SCAN_DIV - 1));
        colsZero   = (cols_i == '0);
        colsOneHot = ($countones(cols_i) == 1);
        colsMatch  = (cols_i == colsLatch_q);
        colNow     = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (cols_i[c]) colNow = CW'(c);
        end
        rowsNext   = {rows_q[NUM_ROWS-2:0], rows_q[NUM_ROWS-1]};
        rowIdxNext = (rowIdx_q == RW'(NUM_ROWS - 1)) ? '0 : rowIdx_q + RW'(1);
        capCol     = (state_q == SCAN) ? colNow : colIdx_q;
        keyIdx     = 32'(rowIdx_q) * NUM_COLS + 32'(capCol);
        if (MAP_MODE == 1) newCode = CODE_W'(PHONE_MAP[keyIdx[3:0]]);
        else               newCode = CODE_W'(keyIdx);

        cntClr = 1'b0;
        cntInc = 1'b0;
        if (sampleEdge) begin
            case (state_q)
                SCAN:     begin cntClr = 1'b1; cntInc = colsOneHot; end
                DEBOUNCE: if (colsMatch) cntInc = !cntLast; else cntClr = 1'b1;
                HELD:     begin cntClr = 1'b1; cntInc = colsZero; end
                RELEASE:  if (colsZero) cntInc = !cntLast; else cntClr = 1'b1;
                default:  cntClr = 1'b1;
            endcase
        end
    end

    key_debounce_ctr #(
        .LIMIT (DEBOUNCE_CNT)
    ) uMatchCtr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cntClr),
        .inc_i  (cntInc),
        .last_o (cntLast)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= SCAN;
            dwell_q      <= '0;
            rows_q       <= NUM_ROWS'(1);
            rowIdx_q     <= '0;
            colsLatch_q  <= '0;
            colIdx_q     <= '0;
            keyCode_q    <= '0;
            keyValid_q   <= 1'b0;
            keyHeld_q    <= 1'b0;
            keyRelease_q <= 1'b0;
        end else begin
            keyValid_q   <= 1'b0;
            keyRelease_q <= 1'b0;
            dwell_q      <= sampleEdge ? '0 : dwell_q + DW'(1);
            if (sampleEdge) begin
                case (state_q)
                    SCAN: begin
                        if (colsOneHot) begin
                            colsLatch_q <= cols_i;
                            colIdx_q    <= colNow;
                            if (DEBOUNCE_CNT == 1) begin
                                state_q    <= HELD;
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                keyCode_q  <= newCode;
                            end else begin
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            rows_q   <= rowsNext;
                            rowIdx_q <= rowIdxNext;
                        end
                    end
                    DEBOUNCE: begin
                        if (colsMatch) begin
                            if (cntLast) begin
                                state_q    <= HELD;
                                keyValid_q <= 1'b1;
                                keyHeld_q  <= 1'b1;
                                keyCode_q  <= newCode;
                            end
                        end else begin
                            state_q  <= SCAN;
                            rows_q   <= rowsNext;
                            rowIdx_q <= rowIdxNext;
                        end
                    end
                    HELD: begin
                        // A single debounce sample means the first all-zero sample is the release.
                        if (colsZero) begin
                            if (DEBOUNCE_CNT == 1) begin
                                state_q      <= SCAN;
                                keyRelease_q <= 1'b1;
                                keyHeld_q    <= 1'b0;
                                rows_q       <= rowsNext;
                                rowIdx_q     <= rowIdxNext;
                            end else begin
                                state_q <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (colsZero) begin
                            if (cntLast) begin
                                state_q      <= SCAN;
                                keyRelease_q <= 1'b1;
                                keyHeld_q    <= 1'b0;
                                rows_q       <= rowsNext;
                                rowIdx_q     <= rowIdxNext;
                            end
                        end else begin
                            state_q <= HELD;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign rows_o        = rows_q;
    assign key_code_o    = keyCode_q;
    assign key_valid_o   = keyValid_q;
    assign key_held_o    = keyHeld_q;
    assign key_release_o = keyRelease_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: default 4x3 phone-map instance plus a 4x4 raw-index instance.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cols;
    logic [3:0] rows;
    logic [3:0] code;
    logic       keyValid;
    logic       keyHeld;
    logic       keyRelease;
    logic [3:0] cols4;
    logic [3:0] rows4;
    logic [3:0] code4;
    logic       keyValid4;
    logic       keyHeld4;
    logic       keyRelease4;

    int errors = 0;
    int checks = 0;
    int validCount = 0;
    int releaseCount = 0;
    int overlapCount = 0;

    always #5 clk = ~clk;

    keypad_scan dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cols_i        (cols),
        .rows_o        (rows),
        .key_code_o    (code),
        .key_valid_o   (keyValid),
        .key_held_o    (keyHeld),
        .key_release_o (keyRelease)
    );

    keypad_scan #(
        .NUM_ROWS (4),
        .NUM_COLS (4),
        .MAP_MODE (0)
    ) dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .cols_i        (cols4),
        .rows_o        (rows4),
        .key_code_o    (code4),
        .key_valid_o   (keyValid4),
        .key_held_o    (keyHeld4),
        .key_release_o (keyRelease4)
    );

    // Pulse monitor for the default instance; tasks read it at negedge+1.
    always @(negedge clk) begin
        if (keyValid) validCount++;
        if (keyRelease) releaseCount++;
        if (keyValid && keyRelease) overlapCount++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish before 2000000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive both column buses, then advance n sample edges (16 clocks each) and settle at negedge+1.
    task automatic applyStimulus(input logic [2:0] c, input logic [3:0] c4, input int n);
        cols  = c;
        cols4 = c4;
        repeat (16 * n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        cols = 3'b000; cols4 = 4'b0000;
        doReset();
        checks++; if (rows !== 4'b0001) begin errors++; $display("[TB] FAIL reset_rows: got %b expected %b", rows, 4'b0001); end
        checks++; if (code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code: got %h expected %h", code, 4'h0); end
        checks++; if ({keyValid, keyHeld, keyRelease} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected %b", {keyValid, keyHeld, keyRelease}, 3'b000); end
        checks++; if (rows4 !== 4'b0001) begin errors++; $display("[TB] FAIL reset_rows4: got %b expected %b", rows4, 4'b0001); end
    endtask

    task automatic test_press();
        int v0;
        doReset();
        v0 = validCount;
        applyStimulus(3'b000, 4'b0000, 1);
        checks++; if (rows !== 4'b0010) begin errors++; $display("[TB] FAIL press_rotate: got %b expected %b", rows, 4'b0010); end
        applyStimulus(3'b001, 4'b0000, 1);
        checks++; if (rows !== 4'b0010) begin errors++; $display("[TB] FAIL press_detect_rows: got %b expected %b", rows, 4'b0010); end
        applyStimulus(3'b001, 4'b0000, 2);
        checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL press_early_valid: got %0d expected %0d", validCount, v0); end
        applyStimulus(3'b001, 4'b0000, 1);
        checks++; if (keyValid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid: got %b expected %b", keyValid, 1'b1); end
        checks++; if (code !== 4'h4) begin errors++; $display("[TB] FAIL press_code: got %h expected %h", code, 4'h4); end
        checks++; if (keyHeld !== 1'b1) begin errors++; $display("[TB] FAIL press_held: got %b expected %b", keyHeld, 1'b1); end
        checks++; if (rows !== 4'b0010) begin errors++; $display("[TB] FAIL press_rows_held: got %b expected %b", rows, 4'b0010); end
    endtask

    task automatic test_release();
        int v0;
        int r0;
        v0 = validCount;
        r0 = releaseCount;
        applyStimulus(3'b000, 4'b0000, 2);
        checks++; if (keyHeld !== 1'b1) begin errors++; $display("[TB] FAIL glitch_held: got %b expected %b", keyHeld, 1'b1); end
        applyStimulus(3'b001, 4'b0000, 1);
        checks++; if (releaseCount !== r0) begin errors++; $display("[TB] FAIL glitch_release: got %0d expected %0d", releaseCount, r0); end
        checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL valid_single_pulse: got %0d expected %0d", validCount, v0); end
        checks++; if (code !== 4'h4) begin errors++; $display("[TB] FAIL code_hold: got %h expected %h", code, 4'h4); end
        applyStimulus(3'b000, 4'b0000, 3);
        checks++; if (releaseCount !== r0 || keyHeld !== 1'b1) begin errors++; $display("[TB] FAIL release_early: got count %0d held %b expected count %0d held 1", releaseCount, keyHeld, r0); end
        applyStimulus(3'b000, 4'b0000, 1);
        checks++; if (keyRelease !== 1'b1) begin errors++; $display("[TB] FAIL release_pulse: got %b expected %b", keyRelease, 1'b1); end
        checks++; if (keyHeld !== 1'b0) begin errors++; $display("[TB] FAIL release_held: got %b expected %b", keyHeld, 1'b0); end
        checks++; if (rows !== 4'b0100) begin errors++; $display("[TB] FAIL release_rows: got %b expected %b", rows, 4'b0100); end
        checks++; if (releaseCount !== r0 + 1) begin errors++; $display("[TB] FAIL release_count: got %0d expected %0d", releaseCount, r0 + 1); end
    endtask

    task automatic test_reset_mid_debounce();
        int v0;
        v0 = validCount;
        applyStimulus(3'b100, 4'b0000, 2);
        checks++; if (rows !== 4'b0100) begin errors++; $display("[TB] FAIL middeb_rows: got %b expected %b", rows, 4'b0100); end
        doReset();
        checks++; if (rows !== 4'b0001) begin errors++; $display("[TB] FAIL middeb_reset_rows: got %b expected %b", rows, 4'b0001); end
        checks++; if ({keyValid, keyHeld, keyRelease} !== 3'b000) begin errors++; $display("[TB] FAIL middeb_flags: got %b expected %b", {keyValid, keyHeld, keyRelease}, 3'b000); end
        checks++; if (code !== 4'h0) begin errors++; $display("[TB] FAIL middeb_code: got %h expected %h", code, 4'h0); end
        applyStimulus(3'b000, 4'b0000, 4);
        checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL middeb_late_valid: got %0d expected %0d", validCount, v0); end
        checks++; if (rows !== 4'b0001) begin errors++; $display("[TB] FAIL middeb_scan_wrap: got %b expected %b", rows, 4'b0001); end
    endtask

    task automatic test_bounce();
        int v0;
        doReset();
        v0 = validCount;
        applyStimulus(3'b000, 4'b0000, 2);
        checks++; if (rows !== 4'b0100) begin errors++; $display("[TB] FAIL bounce_rows_pre: got %b expected %b", rows, 4'b0100); end
        applyStimulus(3'b010, 4'b0000, 2);
        applyStimulus(3'b000, 4'b0000, 1);
        checks++; if (rows !== 4'b1000) begin errors++; $display("[TB] FAIL bounce_rows: got %b expected %b", rows, 4'b1000); end
        checks++; if (validCount !== v0 || keyHeld !== 1'b0) begin errors++; $display("[TB] FAIL bounce_valid: got count %0d held %b expected count %0d held 0", validCount, keyHeld, v0); end
    endtask

    task automatic test_ghost();
        int v0;
        doReset();
        v0 = validCount;
        applyStimulus(3'b011, 4'b0000, 1);
        checks++; if (rows !== 4'b0010) begin errors++; $display("[TB] FAIL ghost_rows: got %b expected %b", rows, 4'b0010); end
        applyStimulus(3'b111, 4'b0000, 1);
        checks++; if (rows !== 4'b0100) begin errors++; $display("[TB] FAIL ghost3_rows: got %b expected %b", rows, 4'b0100); end
        checks++; if (validCount !== v0) begin errors++; $display("[TB] FAIL ghost_valid: got %0d expected %0d", validCount, v0); end
    endtask

    task automatic test_raw_map();
        doReset();
        applyStimulus(3'b000, 4'b0000, 3);
        checks++; if (rows4 !== 4'b1000) begin errors++; $display("[TB] FAIL raw_rows: got %b expected %b", rows4, 4'b1000); end
        applyStimulus(3'b000, 4'b1000, 4);
        checks++; if (keyValid4 !== 1'b1) begin errors++; $display("[TB] FAIL raw_valid_r3c3: got %b expected %b", keyValid4, 1'b1); end
        checks++; if (code4 !== 4'd15) begin errors++; $display("[TB] FAIL raw_code_r3c3: got %0d expected %0d", code4, 15); end
        applyStimulus(3'b000, 4'b0000, 4);
        checks++; if (keyRelease4 !== 1'b1 || keyHeld4 !== 1'b0) begin errors++; $display("[TB] FAIL raw_release: got rel %b held %b expected rel 1 held 0", keyRelease4, keyHeld4); end
        checks++; if (rows4 !== 4'b0001) begin errors++; $display("[TB] FAIL raw_row_wrap: got %b expected %b", rows4, 4'b0001); end
        applyStimulus(3'b000, 4'b0100, 4);
        checks++; if (keyValid4 !== 1'b1) begin errors++; $display("[TB] FAIL raw_valid_r0c2: got %b expected %b", keyValid4, 1'b1); end
        checks++; if (code4 !== 4'd2) begin errors++; $display("[TB] FAIL raw_code_r0c2: got %0d expected %0d", code4, 2); end
        cols4 = 4'b0000;
    endtask

    initial begin
        rst   = 1'b1;
        cols  = 3'b000;
        cols4 = 4'b0000;
        test_reset();
        test_press();
        test_release();
        test_reset_mid_debounce();
        test_bounce();
        test_ghost();
        test_raw_map();
        checks++; if (overlapCount !== 0) begin errors++; $display("[TB] FAIL valid_release_overlap: got %0d expected %0d", overlapCount, 0); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
